// File: rtl/johnson_counter_pkg.sv
// johnson_counter_pkg: shared defaults for the Johnson counter slice
package johnson_counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/johnson_legal_chk.sv
// johnson_legal_chk: flags a word as a legal Johnson codeword (at most one adjacent-bit change)
module johnson_legal_chk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word_i,
  output logic             legal_o
);
  logic [WIDTH-2:0] diff;
  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  always_comb begin
    diff    = word_i[WIDTH-1:1] ^ word_i[WIDTH-2:0];
    legal_o = (diff & (diff - 1'b1)) == '0;
  end
endmodule

// File: rtl/johnson_counter.sv
// johnson_counter: free-running self-correcting WIDTH-bit twisted-ring counter
module johnson_counter
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] q_q = '0;
  logic [WIDTH-1:0] q_d;
  logic             legal;
  johnson_legal_chk #(.WIDTH(WIDTH)) u_chk (
    .word_i (q_q),
    .legal_o(legal)
  );
  // Illegal words collapse to zero so the ring is re-entered at its start.
  always_comb q_d = legal ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]} : '0;
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end
  assign Q = q_q;
endmodule

// File: tb/tb_johnson_counter.sv
// tb_johnson_counter: randomized bench checking 4- and 6-bit counters against a ring-index model
module tb_johnson_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q4;
  logic [5:0] q6;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] m4 = '0, b4, dep4 = '0;
  logic [5:0] m6 = '0, b6, dep6 = '0;
  logic       dep_on = 1'b0;

  always #5 clk = ~clk;

  johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .Q(q4));
  johnson_counter #(.WIDTH(6)) dut6 (.clk(clk), .reset(reset), .Q(q6));

  // i-th word of the w-bit ring: i ones filling from the bottom, then zeros filling from the bottom
  function automatic logic [7:0] word(input int w, input int i);
    logic [7:0] ones;
    ones = 8'((1 << w) - 1);
    return (i <= w) ? 8'((1 << i) - 1) : (ones & ~8'((1 << (i - w)) - 1));
  endfunction

  function automatic logic [7:0] nxt(input int w, input logic [7:0] v);
    for (int i = 0; i < 2 * w; i++)
      if (word(w, i) == v) return word(w, (i + 1) % (2 * w));
    return 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    b4 = dep_on ? dep4 : m4;
    b6 = dep_on ? dep6 : m6;
    m4 = reset ? 4'h0 : 4'(nxt(4, 8'(b4)));
    m6 = reset ? 6'h00 : 6'(nxt(6, 8'(b6)));
  end

  always @(negedge clk) begin
    chk("model4", 8'(q4), 8'(dep_on ? dep4 : m4));
    chk("model6", 8'(q6), 8'(dep_on ? dep6 : m6));
  end

  task automatic step();
    @(posedge clk);
    #3;
    dep_on = 1'b0;
  endtask

  task automatic deposit(input logic [3:0] v4, input logic [5:0] v6);
    dep4 = v4;
    dep6 = v6;
    dep_on = 1'b1;
    force dut4.q_q = dep4;
    force dut6.q_q = dep6;
    #1;
    release dut4.q_q;
    release dut6.q_q;
  endtask

  logic [3:0] seq4 [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] hist [16];

  initial begin
    #1;
    chk("powerup", 8'(q4), 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("seq_powerup", 8'(q4), 8'(seq4[(i + 1) % 8]));
    end
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reach0111", 8'(q4), 8'h07);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", 8'(q4), 8'h00);
    end
    reset = 1'b0;
    step();
    chk("after_release", 8'(q4), 8'h01);
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      hist[i] = q4;
    end
    for (int i = 0; i < 8; i++) begin
      chk("repeat", 8'(hist[i + 8]), 8'(hist[i]));
      chk("seq_free", 8'(hist[i]), 8'(seq4[(i + 1) % 8]));
    end
    for (int i = 1; i < 16; i++) chk("one_toggle", 8'($countones(hist[i] ^ hist[i - 1])), 8'd1);
    deposit(4'b0101, 6'b010101);
    step();
    chk("illegal_clear", 8'(q4), 8'h00);
    step();
    chk("illegal_resume", 8'(q4), 8'h01);
    step();
    reset = 1'b1; #1; reset = 1'b0;
    step();
    chk("glitch_reset_ignored", 8'(q4), 8'h07);
    reset = 1'b1; step(); reset = 1'b0;
    chk("edge_reset", 8'(q4), 8'h00);
    begin
      int k = 0;
      while (q6 != 6'h3F && k < 20) begin step(); k++; end
      chk("reach111111", 8'(k < 20), 8'd1);
      chk("reach_steps6", 8'(k), 8'd6);
      step();
      chk("w6_after_ones", 8'(q6), 8'b0011_1110);
      for (int i = 0; i < 5; i++) step();
      chk("w6_period12", 8'(q6), 8'h00);
    end
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 14) == 0) deposit(4'($urandom), 6'($urandom));
      step();
    end
    reset = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
